// File: rtl/kmeans_apb_regfile_if.sv
// kmeans_apb_regfile_if: APB bus bundle between the host and the k-means register file
interface kmeans_apb_regfile_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 91
);
  logic [ADDR_W-1:0] paddr;
  logic psel;
  logic penable;
  logic pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic pready;
  logic pslverr;
  modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pready, pslverr);
  modport slave (input paddr, psel, penable, pwrite, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/kmeans_apb_regfile.sv
// kmeans_apb_regfile: APB register file with core side port and RAM write sequencer; define KMEANS_RF_AUTOINC_EN to post-increment RAM_ADDR on every RAM strobe
module kmeans_apb_regfile #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 91,
  parameter int NUM_CENT = 8,
  parameter int IDX_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  kmeans_apb_regfile_if.slave apb,
  input  logic interupt,
  input  logic [IDX_W-1:0] reg_num,
  input  logic reg_write,
  input  logic [DATA_W-1:0] reg_write_data,
  output logic [DATA_W-1:0] data2core,
  output logic go_core,
  output logic [DATA_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic ram_we_n,
  output logic ram_cs_n,
  output logic ram_oe_n
);
  localparam int RA = NUM_CENT + 2;
  localparam int RD = NUM_CENT + 3;
  localparam int FA = NUM_CENT + 4;
  localparam int LA = NUM_CENT + 5;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] cent [NUM_CENT];
  logic [DATA_W-1:0] ram_addr, ram_data, first_addr, last_addr;
  logic go, done, acc, err, apb_wr, core_wr, ram_go;
  int a, ri;

  function automatic logic [DATA_W-1:0] rd_reg(input int i);
    logic [DATA_W-1:0] v;
    v = (i == RA) ? ram_addr : (i == RD) ? ram_data : (i == FA) ? first_addr : (i == LA) ? last_addr : '0;
    for (int k = 0; k < NUM_CENT; k++) v = (i == k + 2) ? cent[k] : v;
    return v;
  endfunction

  assign a = 32'(apb.paddr);
  assign ri = 32'(reg_num);
  assign acc = state == ACCESS;
  assign err = acc & ((a > LA) | (apb.pwrite & ((a == 0) | (go & (a != 1)))));
  assign apb_wr = acc & apb.pwrite & ~err;
  assign core_wr = go & reg_write;
  assign ram_go = apb_wr & (a == RD);
  assign apb.pready = acc;
  assign apb.pslverr = err;
  assign apb.prdata = (acc & ~err & ~apb.pwrite) ?
    ((a == 0) ? {{(DATA_W-2){1'b0}}, done, go} : (a == 1) ? DATA_W'(go) : rd_reg(a)) : '0;
  assign ram_oe_n = 1'b1;

  // APB protocol state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // setup on psel without penable, one access cycle, then back to idle
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = (apb.psel & ~apb.penable) ? SETUP : IDLE;
    else if (state == SETUP) state_nx = apb.psel ? ACCESS : IDLE;
  end

  // register file, run control, core side port and RAM write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CENT; k++) cent[k] <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      first_addr <= '0;
      last_addr <= '0;
      go <= 1'b0;
      done <= 1'b0;
      go_core <= 1'b0;
      data2core <= '0;
      ram_cs_n <= 1'b1;
      ram_we_n <= 1'b1;
      ram_addr_o <= '0;
      ram_wdata_o <= '0;
    end else begin
      for (int k = 0; k < NUM_CENT; k++)
        if ((apb_wr && a == k + 2) || (core_wr && ri == k + 2)) cent[k] <= core_wr ? reg_write_data : apb.pwdata;
      if (apb_wr && a == RA) ram_addr <= apb.pwdata;
`ifdef KMEANS_RF_AUTOINC_EN
      else if (ram_go) ram_addr <= ram_addr + DATA_W'(1);
`endif
      if (apb_wr && a == RD) ram_data <= apb.pwdata;
      if (apb_wr && a == FA) first_addr <= apb.pwdata;
      if (apb_wr && a == LA) last_addr <= apb.pwdata;
      if (interupt) begin
        go <= 1'b0;
        done <= 1'b1;
      end else if (apb_wr && a == 1) begin
        go <= apb.pwdata[0];
        if (apb.pwdata[0] && !go) done <= 1'b0;
      end
      go_core <= go;
      if (go && !reg_write) data2core <= rd_reg(ri);
      ram_cs_n <= ~ram_go;
      ram_we_n <= ~ram_go;
      if (ram_go) begin
        ram_addr_o <= ram_addr;
        ram_wdata_o <= apb.pwdata;
      end
    end
  end
endmodule
